sram_march_bist: RTL and testbench

Built-in self-test initiator for the single-port SRAM (`sram_top`: `we`, `addr`, `data_in`, `data_out`). On a `start` pulse it takes over the SRAM port and runs a four-element March sequence over every address. It then reports pass/fail, the first failing address with its expected and observed data, and a saturating error count. It sits between the SRAM and the functional master; a mux selecting BIST or functional traffic using `busy` lives outside this block.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_bist_addr_gen.sv | 44 ++++
 rtl/sram_march_bist.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM March BIST.
// The state and sub-step encodings are visible to the top and to any debug tooling.
package sram_pkg;

  localparam int SRAM_AW = 10;
  localparam int SRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } bist_state_e;

  typedef enum logic [1:0] {
    RD   = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2
  } bist_step_e;

  function automatic logic is_run(input bist_state_e s);
    return s inside {M0, M1, M2, M3};
  endfunction

  function automatic logic is_read_elem(input bist_state_e s);
    return s inside {M1, M2, M3};
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the March elements: load parks it at the first address of an
// element in the requested direction; first/last flag the element boundaries.
module sram_bist_addr_gen
  import sram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = SRAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          down,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic          first,
  output logic          last
);

  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  logic down_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (clr) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      addr   <= down ? TOP : '0;
      down_q <= down;
    end else if (adv) begin
      addr <= down_q ? addr - AW'(1) : addr + AW'(1);
    end
  end

  assign first = down_q ? (addr == TOP) : (addr == '0);
  assign last  = down_q ? (addr == '0)  : (addr == TOP);

endmodule

// File: rtl/sram_march_bist.sv
// March BIST initiator: M0 w(bg); M1 r(bg) w(~bg); M2 (descending) r(~bg) w(bg); M3 r(bg).
// Reports pass/fail, the first failing address with expected/observed data, and an error count.
module sram_march_bist
  import sram_pkg::*;
#(
  parameter int            DEPTH        = 1024,
  parameter int            AW           = SRAM_AW,
  parameter int            DW           = SRAM_DW,
  parameter int            RD_LAT       = 1,
  parameter logic [DW-1:0] PATTERN      = DW'(8'h00),
  parameter bit            STOP_ON_FAIL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  output logic [15:0]   err_cnt,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  // The wait counter runs RD_LAT-2 down to 0, giving RD_LAT-1 WAIT cycles.
  localparam int              WCW       = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WCW-1:0]  WAIT_INIT = WCW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [15:0]     ERR_MAX   = 16'hFFFF;

  bist_state_e    state;
  bist_state_e    state_n;
  bist_step_e     step;
  bist_step_e     step_n;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_n;

  logic           ag_clr;
  logic           ag_load;
  logic           ag_down;
  logic           ag_adv;
  logic [AW-1:0]  ag_addr;
  logic           ag_first;
  logic           ag_last;

  logic           start_ok;
  logic           aborting;
  logic [DW-1:0]  exp_data;
  logic           mismatch;
  logic           latch_fail;
  logic [15:0]    err_n;
  logic           we_n;
  logic [DW-1:0]  wdata_n;

  sram_bist_addr_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ag_clr),
    .load  (ag_load),
    .down  (ag_down),
    .adv   (ag_adv),
    .addr  (ag_addr),
    .first (ag_first),
    .last  (ag_last)
  );

  // The generator is parked at its first ascending address whenever the BIST is idle,
  // so a run always launches from address 0.
  assign start_ok = start && ag_first && (state == IDLE || state == DONE);
  assign aborting = abort && is_run(state);

  assign exp_data   = (state == M2) ? ~PATTERN : PATTERN;
  assign mismatch   = is_read_elem(state) && (step == CMP) && !aborting
                      && (sram_rdata != exp_data);
  assign latch_fail = mismatch && (err_cnt == '0);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    step_n  = step;
    wcnt_n  = wcnt;
    ag_clr  = 1'b0;
    ag_load = 1'b0;
    ag_down = 1'b0;
    ag_adv  = 1'b0;

    if (aborting) begin
      state_n = IDLE;
      step_n  = RD;
      ag_clr  = 1'b1;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state_n = M0;
            step_n  = RD;
          end
        end

        M0: begin
          if (ag_last) begin
            state_n = M1;
            step_n  = RD;
            ag_load = 1'b1;
          end else begin
            ag_adv = 1'b1;
          end
        end

        M1, M2, M3: begin
          unique case (step)
            RD: begin
              if (RD_LAT == 1) begin
                step_n = CMP;
              end else begin
                step_n = WAIT;
                wcnt_n = WAIT_INIT;
              end
            end

            WAIT: begin
              if (wcnt == '0) step_n = CMP;
              else            wcnt_n = wcnt - WCW'(1);
            end

            CMP: begin
              step_n = RD;
              if (mismatch && STOP_ON_FAIL) begin
                state_n = DONE;
                ag_clr  = 1'b1;
              end else if (ag_last) begin
                unique case (state)
                  M1: begin
                    state_n = M2;
                    ag_load = 1'b1;
                    ag_down = 1'b1;
                  end
                  M2: begin
                    state_n = M3;
                    ag_load = 1'b1;
                  end
                  default: begin
                    state_n = DONE;
                    ag_clr  = 1'b1;
                  end
                endcase
              end else begin
                ag_adv = 1'b1;
              end
            end

            default: step_n = RD;
          endcase
        end

        default: begin
          state_n = IDLE;
          step_n  = RD;
          ag_clr  = 1'b1;
        end
      endcase
    end
  end

  // Error count for the coming cycle; a new run starts from zero.
  always_comb begin
    err_n = err_cnt;
    if (start_ok) begin
      err_n = '0;
    end else if (mismatch && err_cnt != ERR_MAX) begin
      err_n = err_cnt + 16'd1;
    end
  end

  // SRAM controls are derived from the next state so the registered outputs line up
  // with the state register: the write of a CMP step is on the bus during that step.
  always_comb begin
    we_n    = (state_n == M0)
              || ((state_n == M1 || state_n == M2) && step_n == CMP);
    wdata_n = '0;
    if (we_n) begin
      wdata_n = (state_n == M1) ? ~PATTERN : PATTERN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= RD;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      wcnt       <= wcnt_n;
      busy       <= is_run(state_n);
      done       <= (state_n == DONE);
      pass       <= (state_n == DONE) && (err_n == '0);
      err_cnt    <= err_n;
      sram_we    <= we_n;
      sram_wdata <= wdata_n;
      if (start_ok) begin
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else if (latch_fail) begin
        fail_addr <= ag_addr;
        fail_exp  <= exp_data;
        fail_got  <= sram_rdata;
      end
    end
  end

  // The address counter is itself a register and is cleared whenever the BIST goes idle.
  assign sram_addr = ag_addr;

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: three configurations, stuck-at SRAM models,
// and a March reference model that predicts results and the per-cycle bus trace.
`timescale 1ns/1ps
module tb_sram_march_bist;

  localparam int         NI = 3;
  localparam int         D  = 16;
  localparam int         LAT  [NI] = '{1, 1, 3};
  localparam logic [7:0] PAT  [NI] = '{8'h00, 8'h00, 8'h5A};
  localparam bit         STOP [NI] = '{1'b1, 1'b0, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        start_s [NI];
  logic        abort_s [NI];
  logic        busy    [NI];
  logic        done    [NI];
  logic        pass    [NI];
  logic [4:0]  faddr   [NI];
  logic [7:0]  fexp    [NI];
  logic [7:0]  fgot    [NI];
  logic [15:0] ecnt    [NI];
  logic        we      [NI];
  logic [4:0]  addr    [NI];
  logic [7:0]  wdata   [NI];
  logic [7:0]  rdata   [NI];

  // SRAM models with a stuck-at bit applied on read
  logic [7:0]  mem  [NI][D];
  logic [7:0]  pipe [NI][4];
  logic [7:0]  rv;
  bit          f_on  [NI];
  int          f_addr[NI];
  int          f_bit [NI];
  bit          f_val [NI];

  int          n_cmp;
  int          n_bad;
  logic [13:0] exp_q[$];
  logic [13:0] mon_e;
  bit          mon_en;
  int          cur;
  int          trace_err;
  int          m_err;
  int          m_cycles;
  int          m_faddr;
  logic [7:0]  m_fexp;
  logic [7:0]  m_fgot;
  int          last_cyc;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_march_bist #(
      .DEPTH        (D),
      .AW           (5),
      .DW           (8),
      .RD_LAT       (LAT[g]),
      .PATTERN      (PAT[g]),
      .STOP_ON_FAIL (STOP[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[g]),
      .abort      (abort_s[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .fail_addr  (faddr[g]),
      .fail_exp   (fexp[g]),
      .fail_got   (fgot[g]),
      .err_cnt    (ecnt[g]),
      .sram_we    (we[g]),
      .sram_addr  (addr[g]),
      .sram_wdata (wdata[g]),
      .sram_rdata (rdata[g])
    );
    assign rdata[g] = pipe[g][LAT[g]-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rv = mem[i][addr[i][3:0]];
      if (f_on[i] && int'(addr[i]) == f_addr[i]) rv[f_bit[i]] = f_val[i];
      for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
      pipe[i][0] <= rv;
      if (we[i]) mem[i][addr[i][3:0]] <= wdata[i];
    end
  end

  // Bus monitor: every busy cycle must match the next predicted {we, addr, wdata}.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy[cur]) begin
        if (exp_q.size() == 0) begin
          trace_err++;
        end else begin
          mon_e = exp_q.pop_front();
          if (we[cur] !== mon_e[13] || addr[cur] !== mon_e[12:8]
              || (mon_e[13] && wdata[cur] !== mon_e[7:0]))
            trace_err++;
        end
      end else if (we[cur] !== 1'b0 || addr[cur] !== 5'd0 || wdata[cur] !== 8'd0) begin
        trace_err++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // March reference: walks the elements over a plain array and records the bus trace.
  task automatic build_model(input int i, input bit fo, input int fa, input int fb, input bit fv);
    logic [7:0] m [D];
    logic [7:0] bg, e, g, wv;
    int         a;
    bit         stopped;
    exp_q.delete();
    m_err = 0; m_faddr = 0; m_fexp = 0; m_fgot = 0; stopped = 0;
    bg = PAT[i];
    for (a = 0; a < D; a++) begin
      m[a] = bg;
      exp_q.push_back({1'b1, 5'(a), bg});
    end
    for (int el = 1; el <= 3 && !stopped; el++) begin
      for (int k = 0; k < D && !stopped; k++) begin
        a  = (el == 2) ? D - 1 - k : k;
        e  = (el == 2) ? ~bg : bg;
        wv = (el == 1) ? ~bg : bg;
        g  = m[a];
        if (fo && a == fa) g[fb] = fv;
        for (int c = 0; c < LAT[i]; c++) exp_q.push_back({1'b0, 5'(a), 8'h00});
        exp_q.push_back({el != 3, 5'(a), (el != 3) ? wv : 8'h00});
        if (el != 3) m[a] = wv;
        if (g != e) begin
          if (m_err == 0) begin
            m_faddr = a; m_fexp = e; m_fgot = g;
          end
          m_err++;
          if (STOP[i]) stopped = 1;
        end
      end
    end
    m_cycles = exp_q.size();
  endtask

  task automatic idle_zero(input int i, input string tag);
    check($sformatf("%s.busy", tag),  busy[i],  0);
    check($sformatf("%s.done", tag),  done[i],  0);
    check($sformatf("%s.pass", tag),  pass[i],  0);
    check($sformatf("%s.we", tag),    we[i],    0);
    check($sformatf("%s.addr", tag),  addr[i],  0);
    check($sformatf("%s.wdata", tag), wdata[i], 0);
    check($sformatf("%s.err", tag),   ecnt[i],  0);
    check($sformatf("%s.faddr", tag), faddr[i], 0);
    check($sformatf("%s.fexp", tag),  fexp[i],  0);
    check($sformatf("%s.fgot", tag),  fgot[i],  0);
  endtask

  // Full run; a start pulse is injected at busy cycle glitch_at (negative = none).
  task automatic run_full(input int i, input bit fo, input int fa, input int fb, input bit fv,
                          input int glitch_at, input string tag);
    int cyc;
    f_on[i] = fo; f_addr[i] = fa; f_bit[i] = fb; f_val[i] = fv;
    build_model(i, fo, fa, fb, fv);
    cur = i; trace_err = 0; mon_en = 1;
    start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    cyc = 0;
    while (busy[i] && cyc < 5000) begin
      start_s[i] = (cyc == glitch_at);
      @(posedge clk); #1;
      cyc++;
    end
    start_s[i] = 1'b0;
    mon_en = 0;
    last_cyc = cyc;
    check($sformatf("%s.cycles", tag), cyc, m_cycles);
    check($sformatf("%s.done", tag), done[i], 1);
    check($sformatf("%s.pass", tag), pass[i], (m_err == 0));
    check($sformatf("%s.err", tag), ecnt[i], m_err);
    check($sformatf("%s.faddr", tag), faddr[i], m_faddr);
    check($sformatf("%s.fexp", tag), fexp[i], m_fexp);
    check($sformatf("%s.fgot", tag), fgot[i], m_fgot);
    check($sformatf("%s.trace", tag), trace_err, 0);
    check($sformatf("%s.trace_left", tag), exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s.done_hold", tag), done[i], 1);
    check($sformatf("%s.busy_hold", tag), busy[i], 0);
  endtask

  // Abort during busy cycle k; the fault (bit 0 stuck at 1) is on address fa when fo=1.
  task automatic run_abort(input int i, input int k, input bit fo, input int fa,
                           input int e_err, input int e_fa, input logic [7:0] e_got,
                           input string tag);
    f_on[i] = fo; f_addr[i] = fa; f_bit[i] = 0; f_val[i] = 1'b1;
    start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1;
    check($sformatf("%s.pre_busy", tag), busy[i], 1);
    abort_s[i] = 1'b1;
    @(posedge clk); #1;
    abort_s[i] = 1'b0;
    check($sformatf("%s.busy", tag), busy[i], 0);
    check($sformatf("%s.we", tag), we[i], 0);
    check($sformatf("%s.done", tag), done[i], 0);
    check($sformatf("%s.err", tag), ecnt[i], e_err);
    check($sformatf("%s.faddr", tag), faddr[i], e_fa);
    check($sformatf("%s.fgot", tag), fgot[i], e_got);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s.stay_idle", tag), busy[i], 0);
  endtask

  initial begin
    int fa, k, ii, fb;
    bit fo, fv;
    n_cmp = 0; n_bad = 0; mon_en = 0; cur = 0; trace_err = 0; last_cyc = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; f_on[i] = 0;
      f_addr[i] = 0; f_bit[i] = 0; f_val[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) idle_zero(i, $sformatf("reset%0d", i));

    // Clean run and the directed stuck-at cases
    run_full(0, 0, 0, 0, 0, -1, "a_clean");
    check("a_clean.N", last_cyc, D + 3 * D * (1 + LAT[0]));
    run_full(0, 1, 5, 0, 1, -1, "a_stop");
    check("a_stop.faddr5", faddr[0], 5);
    check("a_stop.fgot01", fgot[0], 8'h01);
    check("a_stop.err1", ecnt[0], 1);
    run_full(1, 1, 5, 0, 1, -1, "b_run");
    check("b_run.err2", ecnt[1], 2);

    // Start pulses while busy must be ignored
    run_full(1, 0, 0, 0, 0, $urandom_range(5, 100), "b_glitch");

    // Abort at cycle 40 of a clean run, then a clean rerun
    run_abort(1, 40, 0, 0, 0, 0, 8'h00, "b_abort40");
    run_full(1, 0, 0, 0, 0, -1, "b_after_abort");
    check("b_after_abort.N", last_cyc, D + 3 * D * (1 + LAT[1]));

    // Abort after the M1 failure of a faulty address: error state is kept
    fa = $urandom_range(0, D - 1);
    k  = D + 2 * fa + 2 + $urandom_range(1, 8);
    run_abort(1, k, 1, fa, 1, fa, 8'h01, "b_abort_err");

    // Reset for one cycle in the middle of M2
    f_on[2] = 0;
    k = $urandom_range(90, 140);
    start_s[2] = 1'b1;
    @(posedge clk); #1;
    start_s[2] = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1;
    check("c_mid.pre_busy", busy[2], 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_zero(2, "c_midreset");

    run_full(2, 0, 0, 0, 0, -1, "c_clean");
    check("c_clean.N", last_cyc, D + 3 * D * (1 + LAT[2]));

    // Randomized faults across all three configurations
    for (int it = 0; it < 8; it++) begin
      ii = $urandom_range(0, NI - 1);
      fo = ($urandom_range(0, 3) != 0);
      fa = $urandom_range(0, D - 1);
      fb = $urandom_range(0, 7);
      fv = 1'($urandom_range(0, 1));
      run_full(ii, fo, fa, fb, fv, $urandom_range(0, 1) ? $urandom_range(3, 60) : -1,
               $sformatf("rand%0d_i%0d", it, ii));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
